sticker_placer: RTL and testbench
=================================

Name: sticker_placer

Overview:
- Online 2-D shelf-packing engine for a 128x128 canvas.
- One sticker request (height, width) arrives every 4 clock cycles. The block returns the lower-left (x, y) placement for each request at a fixed latency and counts requests that cannot be placed (strikes).
- Sits between the request stream source and the placement consumer.
- Purely synchronous; no handshake.

Parameters:
- CANVAS_W, 128, canvas width in units; placement requires x+w <= CANVAS_W.
- CANVAS_H, 128, canvas height in units; placement requires y+h <= CANVAS_H.
- MAX_SHELVES, 16, number of shelf slots held in registers.
- MAX_DIM, 16, largest legal sticker height or width.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- height_i  input  5  sticker height.
- width_i  input  5  sticker width.
- strike_o  output  4  count of rejected requests, saturating.
- index_x_o  output  8  x of placed sticker's lower-left corner.
- index_y_o  output  8  y of placed sticker's lower-left corner.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_i=0 at a rising edge) clears:
  - strike_o=0, index_x_o=0, index_y_o=0;
  - all shelves closed, shelf count 0, next-shelf base 0;
  - the free-running 2-bit phase counter.
- Timing, with cycle 0 = first rising edge where rst_i=1:
  - Request n is sampled at cycle 4n+1.
  - Its result appears on index_x_o/index_y_o/strike_o at cycle 4n+8 (latency 7 cycles).
  - Outputs are held constant for exactly 4 cycles and stay 0 until cycle 8.
  - The source changes inputs near cycles 4n and holds them stable for 4 cycles.
- Request classes:
  - Null request (h=0 or w=0): no state change; outputs keep their previous values.
  - Illegal request (h>MAX_DIM or w>MAX_DIM): strike.
- Shelf state: each open shelf k has base y B[k], height H[k] and fill F[k]. Shelves are opened in order, bottom-up; T = base of the next new shelf.
- Placement of (h,w), in order:
  - (a) Candidate shelves satisfy H[k] >= h and F[k]+w <= 128. Pick the lowest-index candidate. Output x=F[k], y=B[k]; then F[k] += w.
  - (b) Otherwise, if T+h <= 128 and shelf count < MAX_SHELVES: open a new shelf with B=T, H=h, F=w. Output x=0, y=T; then T += h.
  - (c) Otherwise strike: output x=128, y=128, strike_o += 1. strike_o saturates at 15 and further strikes leave it at 15. No shelf state changes.
- Exact boundary: F+w == 128 fits and T+h == 128 fits.
- A strike does not block later requests; later smaller requests may still place.
- Arithmetic:
  - Use 8-bit unsigned registers for F, B, T.
  - Compare using 9-bit sums so that no wrap-around occurs.
- Reset asserted mid-request: that request is discarded and the 4-cycle schedule restarts from cycle 0 after release.

Optional Feature:
- Macro BEST_FIT_SHELF_EN.
- Defined: step (a) chooses the candidate with minimum H[k]-h. Ties go to the lowest index.
- Undefined: first-fit as described above.
- Steps (b) and (c) and all timing are identical in both builds.

Test Plan:
- Reset, then request (h=4,w=8) -> outputs 0,0 through cycle 7; at cycle 8 (x,y)=(0,0), strike 0, held through cycle 11.
- Sequence (4,8),(3,10),(6,5) -> (0,0),(8,0),(0,4). The second request shares shelf 0; the third opens shelf 1 at y=4.
- Eight requests (4,16) then (4,16) -> x=0,16,...,112 at y=0, then (0,4). Shelf 0 is exactly full at 128.
- Request (17,4) -> (128,128), strike_o=1. Next (2,2) places normally. Sixteen more illegal requests -> strike_o stays 15.
- Requests (8,16) x7 then (0,0) null -> seventh result repeats for the null slot; no strike and no state change.
- Shelves (8,4)@y0 and (4,4)@y8, then request (4,2):
  - macro undefined -> (4,0);
  - macro BEST_FIT_SHELF_EN defined -> (4,8).

Source files
------------

// File: rtl/sticker_placer_if.sv
// ---------------------------------------------------------------------------
// sticker_placer_if
// Request/result bundle for the shelf-packing engine.
//   height_i, width_i     : sticker request (0 in either field = null request)
//   strike_o              : saturating count of rejected requests
//   index_x_o, index_y_o  : lower-left corner of the most recent placement
// Modports:
//   master : request source / placement consumer side
//   slave  : sticker_placer side
// ---------------------------------------------------------------------------
interface sticker_placer_if;
   logic [4:0] height_i;
   logic [4:0] width_i;
   logic [3:0] strike_o;
   logic [7:0] index_x_o;
   logic [7:0] index_y_o;

   modport master (
      output height_i, width_i,
      input  strike_o, index_x_o, index_y_o
   );

   modport slave (
      input  height_i, width_i,
      output strike_o, index_x_o, index_y_o
   );
endinterface

// File: rtl/sticker_placer.sv
// ---------------------------------------------------------------------------
// sticker_placer
// Online 2-D shelf packer for a CANVAS_W x CANVAS_H canvas. One request is
// accepted every 4 cycles; its placement appears 7 cycles after sampling and
// is held for 4 cycles.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active low
//   bus    : sticker_placer_if.slave (height_i, width_i in;
//            strike_o, index_x_o, index_y_o out)
//
// Build option:
//   BEST_FIT_SHELF_EN - when defined, an existing shelf is chosen by the
//   smallest height slack (ties to lowest index); otherwise first fit.
//
// Schedule (phase = cycles since reset release, mod 4):
//   phase 1 edge : request sampled into req_*_reg
//   phase 2 edge : placement decided, shelf state updated, result -> dec_*
//   phase 0 edge : pend_* -> outputs, dec_* -> pend_*
// The extra pend stage makes request n surface at cycle 4n+8.
// ---------------------------------------------------------------------------
module sticker_placer #(
   parameter int CANVAS_W    = 128,
   parameter int CANVAS_H    = 128,
   parameter int MAX_SHELVES = 16,
   parameter int MAX_DIM     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   sticker_placer_if.slave   bus
);

   localparam int IDX_W = $clog2(MAX_SHELVES);
   localparam int CNT_W = $clog2(MAX_SHELVES + 1);

   typedef enum logic [1:0] {PH_0 = 2'd0, PH_1 = 2'd1, PH_2 = 2'd2, PH_3 = 2'd3} phase_t;
   typedef enum logic [1:0] {RES_HOLD = 2'd0, RES_PLACE = 2'd1, RES_STRIKE = 2'd2} res_t;

   phase_t           phase_reg;
   logic [4:0]       req_h_reg;
   logic [4:0]       req_w_reg;

   logic [7:0]       shelf_base_reg   [MAX_SHELVES];
   logic [7:0]       shelf_height_reg [MAX_SHELVES];
   logic [7:0]       shelf_fill_reg   [MAX_SHELVES];
   logic [CNT_W-1:0] shelf_cnt_reg;
   logic [7:0]       top_reg;

   res_t             dec_kind_reg;
   logic [7:0]       dec_x_reg;
   logic [7:0]       dec_y_reg;
   res_t             pend_kind_reg;
   logic [7:0]       pend_x_reg;
   logic [7:0]       pend_y_reg;

   logic [3:0]       strike_reg;
   logic [7:0]       x_reg;
   logic [7:0]       y_reg;

   // ------------------------------------------------------------------
   // Per-shelf candidate test (9-bit sums so x+w cannot wrap)
   // ------------------------------------------------------------------
   logic [MAX_SHELVES-1:0] cand;
   logic [8:0]             fill_sum [MAX_SHELVES];

   generate
      for (genvar gi = 0; gi < MAX_SHELVES; gi++) begin : g_cand
         assign fill_sum[gi] = {1'b0, shelf_fill_reg[gi]} + {4'd0, req_w_reg};
         assign cand[gi]     = (CNT_W'(gi) < shelf_cnt_reg)
                            && (shelf_height_reg[gi] >= {3'd0, req_h_reg})
                            && (fill_sum[gi] <= 9'(CANVAS_W));
      end
   endgenerate

   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;

`ifdef BEST_FIT_SHELF_EN
   logic [7:0] slack [MAX_SHELVES];
   logic [7:0] best_slack;

   generate
      for (genvar gi = 0; gi < MAX_SHELVES; gi++) begin : g_slack
         assign slack[gi] = shelf_height_reg[gi] - {3'd0, req_h_reg};
      end
   endgenerate

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      best_slack = '1;
      for (int k = 0; k < MAX_SHELVES; k++) begin
         if (cand[k] && (!sel_found || (slack[k] < best_slack))) begin
            sel_found  = 1'b1;
            sel_idx    = IDX_W'(k);
            best_slack = slack[k];
         end
      end
   end
`else
   // Scan downward so the lowest-index candidate wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = MAX_SHELVES - 1; k >= 0; k--) begin
         if (cand[k]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(k);
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Placement decision for the sampled request
   // ------------------------------------------------------------------
   logic       is_null;
   logic       is_illegal;
   logic [8:0] top_sum;
   logic       new_ok;
   res_t       nxt_kind;
   logic [7:0] nxt_x;
   logic [7:0] nxt_y;
   logic       do_fill;
   logic       do_open;

   assign is_null    = (req_h_reg == 5'd0) || (req_w_reg == 5'd0);
   assign is_illegal = (req_h_reg > 5'(MAX_DIM)) || (req_w_reg > 5'(MAX_DIM));
   assign top_sum    = {1'b0, top_reg} + {4'd0, req_h_reg};
   assign new_ok     = (top_sum <= 9'(CANVAS_H)) && (shelf_cnt_reg < CNT_W'(MAX_SHELVES));

   always_comb begin
      nxt_kind = RES_HOLD;
      nxt_x    = '0;
      nxt_y    = '0;
      do_fill  = 1'b0;
      do_open  = 1'b0;
      if (is_null) begin
         nxt_kind = RES_HOLD;
      end else if (is_illegal) begin
         nxt_kind = RES_STRIKE;
      end else if (sel_found) begin
         nxt_kind = RES_PLACE;
         nxt_x    = shelf_fill_reg[sel_idx];
         nxt_y    = shelf_base_reg[sel_idx];
         do_fill  = 1'b1;
      end else if (new_ok) begin
         nxt_kind = RES_PLACE;
         nxt_x    = '0;
         nxt_y    = top_reg;
         do_open  = 1'b1;
      end else begin
         nxt_kind = RES_STRIKE;
      end
   end

   // ------------------------------------------------------------------
   // Shelf storage; validity is tracked by shelf_cnt_reg, so the arrays
   // themselves need no reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i && (phase_reg == PH_2)) begin
         if (do_fill) begin
            shelf_fill_reg[sel_idx] <= fill_sum[sel_idx][7:0];
         end
         if (do_open) begin
            shelf_base_reg[shelf_cnt_reg[IDX_W-1:0]]   <= top_reg;
            shelf_height_reg[shelf_cnt_reg[IDX_W-1:0]] <= {3'd0, req_h_reg};
            shelf_fill_reg[shelf_cnt_reg[IDX_W-1:0]]   <= {3'd0, req_w_reg};
         end
      end
   end

   // ------------------------------------------------------------------
   // Phase sequencer, control state and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         phase_reg     <= PH_0;
         req_h_reg     <= '0;
         req_w_reg     <= '0;
         shelf_cnt_reg <= '0;
         top_reg       <= '0;
         dec_kind_reg  <= RES_HOLD;
         dec_x_reg     <= '0;
         dec_y_reg     <= '0;
         pend_kind_reg <= RES_HOLD;
         pend_x_reg    <= '0;
         pend_y_reg    <= '0;
         strike_reg    <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
      end else begin
         case (phase_reg)
            PH_0: begin
               phase_reg     <= PH_1;
               pend_kind_reg <= dec_kind_reg;
               pend_x_reg    <= dec_x_reg;
               pend_y_reg    <= dec_y_reg;
               case (pend_kind_reg)
                  RES_PLACE: begin
                     x_reg <= pend_x_reg;
                     y_reg <= pend_y_reg;
                  end
                  RES_STRIKE: begin
                     x_reg <= 8'(CANVAS_W);
                     y_reg <= 8'(CANVAS_H);
                     if (strike_reg != 4'hF) begin
                        strike_reg <= strike_reg + 4'd1;
                     end
                  end
                  default: ;
               endcase
            end
            PH_1: begin
               phase_reg <= PH_2;
               req_h_reg <= bus.height_i;
               req_w_reg <= bus.width_i;
            end
            PH_2: begin
               phase_reg    <= PH_3;
               dec_kind_reg <= nxt_kind;
               dec_x_reg    <= nxt_x;
               dec_y_reg    <= nxt_y;
               if (do_open) begin
                  shelf_cnt_reg <= shelf_cnt_reg + CNT_W'(1);
                  top_reg       <= top_sum[7:0];
               end
            end
            default: begin
               phase_reg <= PH_0;
            end
         endcase
      end
   end

   assign bus.strike_o  = strike_reg;
   assign bus.index_x_o = x_reg;
   assign bus.index_y_o = y_reg;

endmodule

// File: tb/tb_sticker_placer.sv
// ---------------------------------------------------------------------------
// tb_sticker_placer
// Scoreboard bench: each request slot pushes the reference model's expected
// result; the entry pushed two slots earlier is popped and compared at the
// start of the slot and again three cycles later (hold check).
// ---------------------------------------------------------------------------
module tb_sticker_placer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sticker_placer_if sp_if ();

   sticker_placer dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sp_if)
   );

   typedef struct packed {
      logic [3:0] s;
      logic [7:0] x;
      logic [7:0] y;
   } exp_t;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   // reference shelf model
   int   mb [16];
   int   mh [16];
   int   mf [16];
   int   mcnt;
   int   mt;
   int   mstrike;
   exp_t last_res;

   task automatic check_res(input string tag, input exp_t got, input exp_t want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got s=%0d x=%0d y=%0d, expected s=%0d x=%0d y=%0d",
                  tag, got.s, got.x, got.y, want.s, want.x, want.y);
      end
   endtask

   task automatic model_req(input int h, input int w, output exp_t r);
      int pick;
`ifdef BEST_FIT_SHELF_EN
      int best;
`endif
      if (h == 0 || w == 0) begin
         r = last_res;
         return;
      end
      pick = -1;
      if (h <= 16 && w <= 16) begin
`ifdef BEST_FIT_SHELF_EN
         best = 1000;
         for (int k = 0; k < mcnt; k++)
            if (mh[k] >= h && mf[k] + w <= 128 && (mh[k] - h) < best) begin
               best = mh[k] - h;
               pick = k;
            end
`else
         for (int k = mcnt - 1; k >= 0; k--)
            if (mh[k] >= h && mf[k] + w <= 128) pick = k;
`endif
         if (pick >= 0) begin
            r = '{s: 4'(mstrike), x: 8'(mf[pick]), y: 8'(mb[pick])};
            mf[pick] += w;
         end else if (mt + h <= 128 && mcnt < 16) begin
            r = '{s: 4'(mstrike), x: 8'd0, y: 8'(mt)};
            mb[mcnt] = mt;
            mh[mcnt] = h;
            mf[mcnt] = w;
            mcnt++;
            mt += h;
         end else begin
            pick = -2;
         end
      end else begin
         pick = -2;
      end
      if (pick == -2) begin
         if (mstrike < 15) mstrike++;
         r = '{s: 4'(mstrike), x: 8'd128, y: 8'd128};
      end
      last_res = r;
   endtask

   task automatic model_reset();
      mcnt     = 0;
      mt       = 0;
      mstrike  = 0;
      last_res = '0;
      exp_q.delete();
      // results for requests 0 and 1 are not out yet: outputs read as zero
      exp_q.push_back('0);
      exp_q.push_back('0);
   endtask

   // Leaves time just after the cycle-0 edge.
   task automatic do_reset();
      rst             = 1'b0;
      sp_if.height_i  = '0;
      sp_if.width_i   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // Entered just after the edge of cycle 4n; leaves just after 4n+4.
   task automatic slot(input int h, input int w, input string tag);
      exp_t r, e, got;
      sp_if.height_i = 5'(h);
      sp_if.width_i  = 5'(w);
      model_req(h, w, r);
      exp_q.push_back(r);
      e   = exp_q.pop_front();
      got = '{s: sp_if.strike_o, x: sp_if.index_x_o, y: sp_if.index_y_o};
      check_res(tag, got, e);
      $display("%s: req h=%0d w=%0d | out s=%0d x=%0d y=%0d (exp s=%0d x=%0d y=%0d)",
               tag, h, w, got.s, got.x, got.y, e.s, e.x, e.y);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      got = '{s: sp_if.strike_o, x: sp_if.index_x_o, y: sp_if.index_y_o};
      check_res({tag, "_hold"}, got, e);
      @(posedge clk);
      #1;
   endtask

   task automatic flush(input string tag);
      slot(0, 0, tag);
      slot(0, 0, tag);
   endtask

   initial begin
      sp_if.height_i = '0;
      sp_if.width_i  = '0;

      // basic sharing / new shelf
      do_reset();
      slot(4, 8, "basic0");
      slot(3, 10, "basic1");
      slot(6, 5, "basic2");
      flush("basic_fl");

      // exactly full shelf at x+w == 128
      do_reset();
      for (int i = 0; i < 8; i++) slot(4, 16, "fill");
      slot(4, 16, "fill_new");
      flush("fill_fl");

      // illegal requests, recovery, saturation
      do_reset();
      slot(17, 4, "illegal_h");
      slot(2, 2, "recover");
      slot(4, 17, "illegal_w");
      for (int i = 0; i < 16; i++) slot(17, 4, "sat");
      slot(3, 3, "after_sat");
      flush("sat_fl");

      // null request keeps outputs and state
      do_reset();
      for (int i = 0; i < 7; i++) slot(8, 16, "pre_null");
      slot(0, 0, "null");
      slot(8, 0, "null_w");
      slot(8, 16, "post_null");
      flush("null_fl");

      // first-fit vs best-fit
      do_reset();
      slot(8, 4, "fit0");
      slot(4, 4, "fit1");
      slot(4, 2, "fit_sel");
      flush("fit_fl");

      // top boundary: y+h == 128 fits, then canvas full
      do_reset();
      for (int i = 0; i < 64; i++) slot(16, 16, "top");
      slot(1, 1, "top_full");
      flush("top_fl");

      // shelf-count limit
      do_reset();
      for (int i = 0; i < 128; i++) slot(1, 16, "cnt");
      slot(1, 16, "cnt_full");
      flush("cnt_fl");

      // reset while a request is in flight discards it
      do_reset();
      sp_if.height_i = 5'd4;
      sp_if.width_i  = 5'd8;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      slot(5, 6, "post_rst");
      flush("rst_fl");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
